// File: rtl/i2s_pkg.sv
// Shared types and frame-timing constants for the I2S receive path.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DISCARD,
    RUN
  } rx_state_t;

  localparam int unsigned    CNT_W     = 10;
  localparam logic [3:0]     SHIFT_PH  = 4'hA;
  localparam logic [CNT_W-1:0] LFT_DONE  = 10'h10A;
  localparam logic [CNT_W-1:0] RGHT_DONE = 10'h30A;
  localparam logic [CNT_W-1:0] FRAME_END = 10'h3FF;

endpackage

// File: rtl/i2s_clk_gen.sv
// Free-running frame counter, registered codec clocks and per-frame timing strobes.
module i2s_clk_gen
  import i2s_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic       mclk_o,
  output logic       sclk_o,
  output logic       lrclk_o,
  output logic       shift_stb_o,
  output logic [4:0] slot_o,
  output logic       lft_done_o,
  output logic       rght_done_o,
  output logic       frame_end_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mclk_q, sclk_q, lrclk_q;

  // Counter wraps 0x3FF -> 0x000 through natural overflow.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
  end

  // Clocks are flopped from the next count so they track cnt_q exactly, glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      mclk_q  <= 1'b0;
      sclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      mclk_q  <= cnt_d[1];
      sclk_q  <= cnt_d[3];
      lrclk_q <= cnt_d[9];
    end
  end

  assign mclk_o      = mclk_q;
  assign sclk_o      = sclk_q;
  assign lrclk_o     = lrclk_q;
  assign slot_o      = cnt_q[8:4];
  // Two clks after SCLK rises, so the synchronized bit is settled.
  assign shift_stb_o = (cnt_q[3:0] == SHIFT_PH);
  assign lft_done_o  = (cnt_q == LFT_DONE);
  assign rght_done_o = (cnt_q == RGHT_DONE);
  assign frame_end_o = (cnt_q == FRAME_END);

endmodule

// File: rtl/i2s_codec_rx.sv
// I2S master receiver: deserializes the codec ADC stream into truncated stereo samples.
module i2s_codec_rx
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_BITS = 24,
  parameter int unsigned OUT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             I2S_data,
  output logic             I2S_mclk,
  output logic             I2S_sclk,
  output logic             I2S_lrclk,
  output logic [OUT_W-1:0] lft_smpl,
  output logic [OUT_W-1:0] rght_smpl,
  output logic             vld
);

  if (DATA_BITS < OUT_W || DATA_BITS > 31) begin : g_bad_data_bits
    $error("DATA_BITS must lie between OUT_W and 31");
  end

  // Slots past this one carry the low-order bits that are dropped (truncation).
  localparam logic [4:0] LAST_SLOT = 5'(OUT_W);

  logic       shift_stb, lft_done, rght_done, frame_end;
  logic [4:0] slot;

  i2s_clk_gen u_clk_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .mclk_o      (I2S_mclk),
    .sclk_o      (I2S_sclk),
    .lrclk_o     (I2S_lrclk),
    .shift_stb_o (shift_stb),
    .slot_o      (slot),
    .lft_done_o  (lft_done),
    .rght_done_o (rght_done),
    .frame_end_o (frame_end)
  );

  logic             sync1_q, sync2_q;
  logic [OUT_W-1:0] shift_q, shift_d;
  logic [OUT_W-1:0] lft_hold_q, lft_hold_d;
  logic [OUT_W-1:0] lft_smpl_q, lft_smpl_d;
  logic [OUT_W-1:0] rght_smpl_q, rght_smpl_d;
  logic             vld_q, vld_d;
  rx_state_t        state_q, state_d;

  // Shift, capture and output next-state; done strobes use the shift result of the same cycle.
  always_comb begin
    shift_d     = shift_q;
    lft_hold_d  = lft_hold_q;
    lft_smpl_d  = lft_smpl_q;
    rght_smpl_d = rght_smpl_q;
    vld_d       = 1'b0;
    // Slot 0 is the I2S one-bit delay and never shifts in.
    if (shift_stb && (slot != 5'd0) && (slot <= LAST_SLOT)) begin
      shift_d = {shift_q[OUT_W-2:0], sync2_q};
    end
    if (lft_done) begin
      lft_hold_d = shift_d;
    end
    if (rght_done && (state_q == RUN)) begin
      lft_smpl_d  = lft_hold_q;
      rght_smpl_d = shift_d;
      vld_d       = 1'b1;
    end
  end

  // Startup sequencing: one idle cycle, then drop the first possibly misaligned frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = DISCARD;
      DISCARD: if (frame_end) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // All datapath, synchronizer and FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      shift_q     <= '0;
      lft_hold_q  <= '0;
      lft_smpl_q  <= '0;
      rght_smpl_q <= '0;
      vld_q       <= 1'b0;
      state_q     <= IDLE;
    end else begin
      sync1_q     <= I2S_data;
      sync2_q     <= sync1_q;
      shift_q     <= shift_d;
      lft_hold_q  <= lft_hold_d;
      lft_smpl_q  <= lft_smpl_d;
      rght_smpl_q <= rght_smpl_d;
      vld_q       <= vld_d;
      state_q     <= state_d;
    end
  end

  assign lft_smpl  = lft_smpl_q;
  assign rght_smpl = rght_smpl_q;
  assign vld       = vld_q;

endmodule
